// File: rtl/fir_resampler_ctrl.sv
// fir_resampler_ctrl: output-request pacing and coefficient reload sequencing
// for the FIR resampler datapath.
//
// Optional build macro FIR_RESAMPLER_CTRL_STATS_EN adds free-running counters
// of request strobes (req_cnt_o) and accepted samples (smp_cnt_o).
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | normal pacing, source ungated, coefficients in use
// DRAIN | source gated, issue remaining requests until acc < DECIMATION
// LOAD  | accept FILTER_ORDER host coefficients onto the write bus
// FLUSH | pacing active, output muted while the filter history refills
module fir_resampler_ctrl #(
    parameter int unsigned FILTER_ORDER  = 256,
    parameter int unsigned INTERPOLATION = 4,
    parameter int unsigned DECIMATION    = 3,
    parameter int unsigned COEF_WIDTH    = 16,
    parameter int unsigned ACC_WIDTH     = 16,
    parameter int unsigned COEF_AWIDTH   = $clog2(FILTER_ORDER)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   smp_val_i,
    output logic                   smp_gate_o,
    output logic                   req_o,
    output logic                   mute_o,
    input  logic                   reload_i,
    input  logic [COEF_WIDTH-1:0]  cfg_data_i,
    input  logic                   cfg_val_i,
    output logic                   cfg_rdy_o,
    output logic                   coef_we_o,
    output logic [COEF_AWIDTH-1:0] coef_addr_o,
    output logic [COEF_WIDTH-1:0]  coef_data_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   ovf_o
`ifdef FIR_RESAMPLER_CTRL_STATS_EN
    ,
    output logic [31:0]            req_cnt_o,
    output logic [31:0]            smp_cnt_o
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam int unsigned FLUSH_SMP = FILTER_ORDER / INTERPOLATION;

    localparam logic [ACC_WIDTH:0]   INC_EXT   = (ACC_WIDTH+1)'(INTERPOLATION);
    localparam logic [ACC_WIDTH:0]   DEC_EXT   = (ACC_WIDTH+1)'(DECIMATION);
    localparam logic [COEF_AWIDTH-1:0] LAST_IDX  = COEF_AWIDTH'(FILTER_ORDER - 1);
    localparam logic [COEF_AWIDTH-1:0] FLUSH_TOP = COEF_AWIDTH'(FLUSH_SMP - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH:0]     acc_ext;
    logic [ACC_WIDTH-1:0]   acc_nxt;
    logic                   acc_sat;
    logic                   hit;
    logic                   add;
    logic                   beat;
    logic                   last_beat;
    logic                   pacing;
    logic                   start_reload;
    logic [COEF_AWIDTH-1:0] beat_idx;
    logic [COEF_AWIDTH-1:0] flush_cnt;
    logic                   flush_tc;

    // Handshake qualifiers are decoded from the state register directly so
    // they never depend on the combinational FSM outputs.
    assign pacing       = (state != LOAD);
    assign add          = smp_val_i && ((state == RUN) || (state == FLUSH));
    assign beat         = cfg_val_i && (state == LOAD);
    assign last_beat    = (beat_idx == LAST_IDX);
    assign flush_tc     = (flush_cnt == '0);
    assign start_reload = (state == RUN) && reload_i;
    assign hit          = ({1'b0, acc} >= DEC_EXT);

    // Phase accumulator next value, widened by one bit to detect saturation.
    always_comb begin
        acc_ext = {1'b0, acc} + (add ? INC_EXT : '0) - (hit ? DEC_EXT : '0);
        acc_sat = acc_ext[ACC_WIDTH];
        acc_nxt = acc_sat ? '1 : acc_ext[ACC_WIDTH-1:0];
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= RUN;
        else       state <= state_nxt;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nxt  = state;
        smp_gate_o = 1'b0;
        cfg_rdy_o  = 1'b0;
        mute_o     = 1'b0;
        busy_o     = 1'b1;
        case (state)
            RUN: begin
                smp_gate_o = 1'b1;
                busy_o     = 1'b0;
                if (reload_i) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!hit) state_nxt = LOAD;
            end
            LOAD: begin
                cfg_rdy_o = 1'b1;
                if (beat && last_beat) state_nxt = FLUSH;
            end
            FLUSH: begin
                smp_gate_o = 1'b1;
                mute_o     = 1'b1;
                if (add && flush_tc) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // Accumulator, request strobe, coefficient bus and flush timer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc         <= '0;
            req_o       <= 1'b0;
            ovf_o       <= 1'b0;
            coef_we_o   <= 1'b0;
            coef_addr_o <= '0;
            coef_data_o <= '0;
            beat_idx    <= '0;
            flush_cnt   <= '0;
            done_o      <= 1'b0;
        end else begin
            coef_we_o <= 1'b0;
            done_o    <= 1'b0;
            req_o     <= 1'b0;

            if (pacing) begin
                acc   <= acc_nxt;
                req_o <= hit;
                if (acc_sat) ovf_o <= 1'b1;
            end

            // A fresh reload clears the sticky flag and rewinds the address.
            if (start_reload) begin
                ovf_o    <= 1'b0;
                beat_idx <= '0;
            end

            if (beat) begin
                coef_we_o   <= 1'b1;
                coef_addr_o <= beat_idx;
                coef_data_o <= cfg_data_i;
                beat_idx    <= beat_idx + 1'b1;
                if (last_beat) begin
                    acc       <= '0;
                    beat_idx  <= '0;
                    flush_cnt <= FLUSH_TOP;
                end
            end

            if ((state == FLUSH) && add) begin
                if (flush_tc) done_o    <= 1'b1;
                else          flush_cnt <= flush_cnt - 1'b1;
            end
        end
    end

`ifdef FIR_RESAMPLER_CTRL_STATS_EN
    // Free-running statistics; wrap naturally, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_cnt_o <= '0;
            smp_cnt_o <= '0;
        end else begin
            if (req_o) req_cnt_o <= req_cnt_o + 32'd1;
            if (add)   smp_cnt_o <= smp_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_resampler_ctrl.sv
// Directed bench for fir_resampler_ctrl: pacing, saturation (narrow
// accumulator instance), reload with backpressure, reset mid-load, flush.
module tb_fir_resampler_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default parameters)
    logic        rst, smp_val, reload, cfg_val;
    logic [15:0] cfg_data;
    logic        smp_gate, req, mute, cfg_rdy, coef_we, busy, done, ovf;
    logic [7:0]  coef_addr;
    logic [15:0] coef_data;

    // Narrow-accumulator instance for saturation
    logic        rst2, smp2, reload2;
    logic        smp_gate2, req2, mute2, cfg_rdy2, coef_we2, busy2, done2, ovf2;
    logic [7:0]  coef_addr2;
    logic [15:0] coef_data2;

`ifdef FIR_RESAMPLER_CTRL_STATS_EN
    logic [31:0] req_cnt, smp_cnt, req_cnt2, smp_cnt2;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] pace_acc [12] = '{16'd4, 16'd1, 16'd1, 16'd1, 16'd5, 16'd2,
                                   16'd2, 16'd2, 16'd6, 16'd3, 16'd0, 16'd0};
    logic        pace_req [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    fir_resampler_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .smp_val_i   (smp_val),
        .smp_gate_o  (smp_gate),
        .req_o       (req),
        .mute_o      (mute),
        .reload_i    (reload),
        .cfg_data_i  (cfg_data),
        .cfg_val_i   (cfg_val),
        .cfg_rdy_o   (cfg_rdy),
        .coef_we_o   (coef_we),
        .coef_addr_o (coef_addr),
        .coef_data_o (coef_data),
        .busy_o      (busy),
        .done_o      (done),
        .ovf_o       (ovf)
`ifdef FIR_RESAMPLER_CTRL_STATS_EN
        ,
        .req_cnt_o   (req_cnt),
        .smp_cnt_o   (smp_cnt)
`endif
    );

    fir_resampler_ctrl #(.ACC_WIDTH(4)) dut2 (
        .clk_i       (clk),
        .rst_i       (rst2),
        .smp_val_i   (smp2),
        .smp_gate_o  (smp_gate2),
        .req_o       (req2),
        .mute_o      (mute2),
        .reload_i    (reload2),
        .cfg_data_i  (16'h0000),
        .cfg_val_i   (1'b0),
        .cfg_rdy_o   (cfg_rdy2),
        .coef_we_o   (coef_we2),
        .coef_addr_o (coef_addr2),
        .coef_data_o (coef_data2),
        .busy_o      (busy2),
        .done_o      (done2),
        .ovf_o       (ovf2)
`ifdef FIR_RESAMPLER_CTRL_STATS_EN
        ,
        .req_cnt_o   (req_cnt2),
        .smp_cnt_o   (smp_cnt2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " req"},       32'(req),       32'd0);
        chk({tag, " coef_we"},   32'(coef_we),   32'd0);
        chk({tag, " coef_addr"}, 32'(coef_addr), 32'd0);
        chk({tag, " coef_data"}, 32'(coef_data), 32'd0);
        chk({tag, " cfg_rdy"},   32'(cfg_rdy),   32'd0);
        chk({tag, " smp_gate"},  32'(smp_gate),  32'd1);
        chk({tag, " mute"},      32'(mute),      32'd0);
        chk({tag, " busy"},      32'(busy),      32'd0);
        chk({tag, " done"},      32'(done),      32'd0);
        chk({tag, " ovf"},       32'(ovf),       32'd0);
        chk({tag, " acc"},       32'(dut.acc),   32'd0);
    endtask

    initial begin
        int n_req;
        int beat;
        logic [31:0] exp_acc2;

        rst = 1'b1; smp_val = 1'b0; reload = 1'b0; cfg_val = 1'b0; cfg_data = '0;
        rst2 = 1'b1; smp2 = 1'b0; reload2 = 1'b0;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;

        // Pacing: samples on cycles 0, 4, 8 from acc=0
        n_req = 0;
        for (int i = 0; i < 12; i++) begin
            smp_val = (i == 0) || (i == 4) || (i == 8);
            tick();
            smp_val = 1'b0;
            chk($sformatf("pace acc[%0d]", i), 32'(dut.acc), 32'(pace_acc[i]));
            chk($sformatf("pace req[%0d]", i), 32'(req),     32'(pace_req[i]));
            if (req) n_req++;
        end
        chk("pace req count", 32'(n_req), 32'd4);

        // Saturation on 4-bit accumulator: acc = n+3 after n edges, clamps at 15
        rst2 = 1'b0;
        smp2 = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            exp_acc2 = (n + 3 > 15) ? 32'd15 : 32'(n + 3);
            chk($sformatf("sat acc[%0d]", n), 32'(dut2.acc), exp_acc2);
            chk($sformatf("sat ovf[%0d]", n), 32'(ovf2),     (n >= 13) ? 32'd1 : 32'd0);
        end
        smp2 = 1'b0;
        for (int n = 0; n < 10; n++) tick();
        chk("sat drained acc", 32'(dut2.acc), 32'd0);
        chk("sat ovf sticky",  32'(ovf2),     32'd1);
        reload2 = 1'b1;
        tick();
        reload2 = 1'b0;
        chk("sat ovf clr on reload", 32'(ovf2),  32'd0);
        chk("sat busy on reload",    32'(busy2), 32'd1);

        // Reload A: bring acc to 5, then reload
        smp_val = 1'b1; tick(); smp_val = 1'b0;
        tick();
        smp_val = 1'b1; tick(); smp_val = 1'b0;
        chk("pre-reload acc", 32'(dut.acc), 32'd5);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("drain busy",     32'(busy),     32'd1);
        chk("drain gate",     32'(smp_gate), 32'd0);
        chk("drain req",      32'(req),      32'd1);
        chk("drain acc",      32'(dut.acc),  32'd2);
        chk("drain cfg_rdy",  32'(cfg_rdy),  32'd0);
        smp_val = 1'b1;
        tick();
        chk("load cfg_rdy",   32'(cfg_rdy),  32'd1);
        chk("load req",       32'(req),      32'd0);
        chk("load acc gated", 32'(dut.acc),  32'd2);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        smp_val = 1'b0;
        chk("load reload ign rdy", 32'(cfg_rdy), 32'd1);
        chk("load reload ign busy", 32'(busy),   32'd1);
        chk("load acc held",       32'(dut.acc), 32'd2);
        chk("load no we",          32'(coef_we), 32'd0);

        // Backpressure: cfg_val toggles 50%
        beat = 0;
        for (int k = 0; k < 20; k++) begin
            cfg_val  = (k % 2 == 0);
            cfg_data = 16'(beat) ^ 16'hA5A5;
            tick();
            if (cfg_val) beat++;
            chk($sformatf("bp we[%0d]", k),   32'(coef_we),   32'(cfg_val));
            chk($sformatf("bp addr[%0d]", k), 32'(coef_addr), 32'(beat - 1));
        end
        cfg_val = 1'b1;
        for (int b = 10; b < 100; b++) begin
            cfg_data = 16'(b) ^ 16'hA5A5;
            tick();
            chk($sformatf("la addr[%0d]", b), 32'(coef_addr), 32'(b));
            chk($sformatf("la data[%0d]", b), 32'(coef_data), 32'(16'(b) ^ 16'hA5A5));
        end

        // Reset mid-load at beat 100
        cfg_data = 16'd100 ^ 16'hA5A5;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cfg_val = 1'b0;
        chk_reset("midload");

        // Reload B: full coefficient set
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("rb busy", 32'(busy),     32'd1);
        chk("rb gate", 32'(smp_gate), 32'd0);
        tick();
        chk("rb cfg_rdy", 32'(cfg_rdy), 32'd1);
        cfg_val = 1'b1;
        for (int b = 0; b < 256; b++) begin
            cfg_data = 16'(b) ^ 16'hA5A5;
            tick();
            chk($sformatf("lb we[%0d]", b),   32'(coef_we),   32'd1);
            chk($sformatf("lb addr[%0d]", b), 32'(coef_addr), 32'(b));
            chk($sformatf("lb data[%0d]", b), 32'(coef_data), 32'(16'(b) ^ 16'hA5A5));
        end
        chk("flush cfg_rdy", 32'(cfg_rdy),  32'd0);
        chk("flush mute",    32'(mute),     32'd1);
        chk("flush acc",     32'(dut.acc),  32'd0);
        chk("flush gate",    32'(smp_gate), 32'd1);
        chk("flush busy",    32'(busy),     32'd1);
        cfg_data = 16'd256 ^ 16'hA5A5;
        tick();
        chk("no beat 257 we",   32'(coef_we),   32'd0);
        chk("no beat 257 addr", 32'(coef_addr), 32'd255);
        cfg_val = 1'b0;

        // Flush: 64 accepted samples spaced 2 cycles
        for (int k = 0; k < 64; k++) begin
            smp_val = 1'b1;
            tick();
            smp_val = 1'b0;
            chk($sformatf("fl mute[%0d]", k), 32'(mute), (k < 63) ? 32'd1 : 32'd0);
            chk($sformatf("fl done[%0d]", k), 32'(done), (k == 63) ? 32'd1 : 32'd0);
            chk($sformatf("fl busy[%0d]", k), 32'(busy), (k < 63) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("fl done off[%0d]", k), 32'(done), 32'd0);
        end
        chk("run gate", 32'(smp_gate), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
